// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - glyphs, digit codes, slot indices and converter states for the clock display
package clock_disp_pkg;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;

    localparam logic [1:0] HI_TENS = 2'd3;
    localparam logic [1:0] HI_ONES = 2'd2;
    localparam logic [1:0] LO_TENS = 2'd1;
    localparam logic [1:0] LO_ONES = 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        CONV_HI,
        CONV_LO,
        COMMIT
    } conv_state_t;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:      return SEG_0;
            4'd1:      return SEG_1;
            4'd2:      return SEG_2;
            4'd3:      return SEG_3;
            4'd4:      return SEG_4;
            4'd5:      return SEG_5;
            4'd6:      return SEG_6;
            4'd7:      return SEG_7;
            4'd8:      return SEG_8;
            4'd9:      return SEG_9;
            CODE_DASH: return SEG_DASH;
            default:   return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/clock_seg_display_bin2bcd.sv
// rtl/clock_seg_display_bin2bcd.sv - sequential 6-bit binary to two-digit BCD by repeated subtract-10
module bin2bcd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [5:0] val;

    // The load cycle already performs the first subtraction, so 59 finishes in five steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            val  <= 6'd0;
            tens <= 4'd0;
            busy <= 1'b0;
        end else if (start && !busy) begin
            val  <= (bin >= 6'd10) ? bin - 6'd10 : bin;
            tens <= (bin >= 6'd10) ? 4'd1 : 4'd0;
            busy <= 1'b1;
        end else if (busy) begin
            if (val >= 6'd10) begin
                val  <= val - 6'd10;
                tens <= tens + 4'd1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (val < 6'd10);
    assign ones = val[3:0];

endmodule

// File: rtl/clock_seg_display.sv
// rtl/clock_seg_display.sv - frame-snapshotted time bus to 4-digit multiplexed common-anode display
module clock_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       mode,
    input  logic       show_seconds,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic       pm,
    output logic       range_err
);
    import clock_disp_pkg::*;

    localparam int CNT_W = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 16) begin : g_bad_div
        $error("REFRESH_DIV must be at least 16");
    end

    logic [CNT_W-1:0] pre_cnt;
    logic [1:0]       idx;
    logic             slot_tick, frame_tick;

    assign slot_tick  = (pre_cnt == CNT_W'(REFRESH_DIV - 1));
    assign frame_tick = slot_tick && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            idx     <= 2'd0;
        end else begin
            pre_cnt <= slot_tick ? '0 : pre_cnt + CNT_W'(1);
            if (slot_tick) idx <= idx + 2'd1;
        end
    end

    conv_state_t     state;
    logic [5:0]      s_sec, s_min;
    logic [4:0]      s_hr;
    logic            s_mode, s_ss;
    logic            hr_bad, min_bad, sec_bad, hi_bad, lo_bad;
    logic [4:0]      hr_disp;
    logic [5:0]      hi_val, lo_val;

    always_comb begin
        hr_bad  = s_hr > 5'd23;
        min_bad = s_min > 6'd59;
        sec_bad = s_sec > 6'd59;
        hr_disp = s_hr;
        if (s_mode) begin
            if (s_hr == 5'd0)       hr_disp = 5'd12;
            else if (s_hr > 5'd12)  hr_disp = s_hr - 5'd12;
        end
        hi_val = s_ss ? s_min : {1'b0, hr_disp};
        lo_val = s_ss ? s_sec : s_min;
        hi_bad = s_ss ? min_bad : hr_bad;
        lo_bad = s_ss ? sec_bad : min_bad;
    end

    logic       conv_start, conv_busy, conv_done;
    logic [3:0] conv_tens, conv_ones;

    assign conv_start = ((state == CONV_HI) || (state == CONV_LO)) && !conv_busy;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   ((state == CONV_LO) ? lo_val : hi_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    logic [3:0]      hi_tens, hi_ones, lo_tens, lo_ones;
    logic [3:0][3:0] digits;
    logic            colon_on, shown, lz;

    assign lz = LZ_BLANK && s_mode && !s_ss && (hi_tens == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_sec     <= 6'd0;
            s_min     <= 6'd0;
            s_hr      <= 5'd0;
            s_mode    <= 1'b0;
            s_ss      <= 1'b0;
            hi_tens   <= 4'd0;
            hi_ones   <= 4'd0;
            lo_tens   <= 4'd0;
            lo_ones   <= 4'd0;
            digits    <= {4{CODE_BLANK}};
            colon_on  <= 1'b0;
            shown     <= 1'b0;
            pm        <= 1'b0;
            range_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_tick) begin
                    s_sec  <= seconds;
                    s_min  <= minutes;
                    s_hr   <= hours;
                    s_mode <= mode;
                    s_ss   <= show_seconds;
                    state  <= CONV_HI;
                end
                CONV_HI: if (conv_done) begin
                    hi_tens <= conv_tens;
                    hi_ones <= conv_ones;
                    state   <= CONV_LO;
                end
                CONV_LO: if (conv_done) begin
                    lo_tens <= conv_tens;
                    lo_ones <= conv_ones;
                    state   <= COMMIT;
                end
                COMMIT: begin
                    // Everything visible changes on this one edge so a frame never mixes two snapshots.
                    digits[HI_TENS] <= hi_bad ? CODE_DASH : (lz ? CODE_BLANK : hi_tens);
                    digits[HI_ONES] <= hi_bad ? CODE_DASH : hi_ones;
                    digits[LO_TENS] <= lo_bad ? CODE_DASH : lo_tens;
                    digits[LO_ONES] <= lo_bad ? CODE_DASH : lo_ones;
                    pm        <= s_mode && !hr_bad && (s_hr >= 5'd12);
                    range_err <= hr_bad || min_bad || sec_bad;
                    colon_on  <= s_ss || !s_sec[0];
                    shown     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !shown) begin
            an   <= 4'hF;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(4'b0001 << idx);
            seg  <= glyph(digits[idx]);
            dp_n <= !((idx == HI_ONES) && colon_on);
        end
    end

endmodule
